// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a (freq, volume, duration) note table and
// drives tone_generator freq/volume/output_enable.
// Ports: clk, rst (async, active high); wr_en/wr_addr/wr_freq/wr_vol/wr_dur
//   write one table entry; seq_len, loop_en, start, stop control playback;
//   freq/volume/output_enable to the generator; busy, done, cur_idx status.
// Optional: define TONE_SEQ_GAP_EN for a GAP_MS silent gap after each note.
module tone_sequencer #(
  parameter int CLK_HZ = 125_000_000,
  parameter int DEPTH  = 16,
  parameter int FREQ_W = 24,
  parameter int DUR_W  = 16,
  parameter int GAP_MS = 10,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [FREQ_W-1:0] wr_freq,
  input  logic              wr_vol,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic [AW:0]       seq_len,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic [FREQ_W-1:0] freq,
  output logic              volume,
  output logic              output_enable,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     cur_idx
);

  localparam int TPM = CLK_HZ / 1000;
  localparam int CW  = $clog2(TPM);

  localparam logic [CW-1:0]    CYC_LAST = CW'(TPM - 1);
  localparam logic [CW-1:0]    CYC_ONE  = CW'(1);
  localparam logic [DUR_W-1:0] MS_ONE   = DUR_W'(1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);
  localparam logic [AW:0]      IDX_ONE  = (AW+1)'(1);

  // GAP is only reachable when TONE_SEQ_GAP_EN is defined.
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  logic [FREQ_W-1:0] mem_f [DEPTH];
  logic              mem_v [DEPTH];
  logic [DUR_W-1:0]  mem_d [DEPTH];

  state_t            state_q;
  logic [AW:0]       idx_q, idx_d, len_q;
  logic [CW-1:0]     cyc_q;
  logic [DUR_W-1:0]  ms_q, dur_q;
  logic [FREQ_W-1:0] freq_q;
  logic              vol_q, oe_q, done_q;

  logic [DUR_W-1:0]  ent_dur;
  logic              last, ms_tick, note_end, gap_end, ent_skip, adv;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_f[wr_addr] <= wr_freq;
      mem_v[wr_addr] <= wr_vol;
      mem_d[wr_addr] <= wr_dur;
    end
  end

  assign ent_dur = mem_d[idx_q[AW-1:0]];

  always_comb begin
    last     = (idx_q == len_q - IDX_ONE);
    idx_d    = last ? '0 : idx_q + IDX_ONE;
    ms_tick  = (cyc_q == CYC_LAST);
    note_end = (state_q == PLAY) && ms_tick
               && (ms_q == dur_q - MS_ONE);
    gap_end  = (state_q == GAP) && ms_tick
               && (ms_q == GAP_LAST);
    ent_skip = (state_q == LOAD) && (ent_dur == '0);
`ifdef TONE_SEQ_GAP_EN
    adv      = ent_skip || gap_end;
`else
    adv      = ent_skip || note_end;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cyc_q   <= '0;
      ms_q    <= '0;
      dur_q   <= '0;
      freq_q  <= '0;
      vol_q   <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
        idx_q   <= '0;
        freq_q  <= '0;
        vol_q   <= 1'b0;
        oe_q    <= 1'b0;
      end else if (adv) begin
        if (last && !loop_en) begin
          state_q <= IDLE;
          freq_q  <= '0;
          vol_q   <= 1'b0;
          oe_q    <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= LOAD;
          idx_q   <= idx_d;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              if (seq_len != '0) begin
                state_q <= LOAD;
                idx_q   <= '0;
                len_q   <= seq_len;
              end else begin
                done_q  <= 1'b1;
              end
            end
          end
          LOAD: begin
            freq_q  <= mem_f[idx_q[AW-1:0]];
            vol_q   <= mem_v[idx_q[AW-1:0]];
            oe_q    <= 1'b1;
            dur_q   <= ent_dur;
            cyc_q   <= '0;
            ms_q    <= '0;
            state_q <= PLAY;
          end
          PLAY, GAP: begin
            // note_end here only when gaps are built in
            if (note_end) begin
              state_q <= GAP;
              freq_q  <= '0;
              vol_q   <= 1'b0;
              cyc_q   <= '0;
              ms_q    <= '0;
            end else begin
              cyc_q <= ms_tick ? '0 : cyc_q + CYC_ONE;
              if (ms_tick) ms_q <= ms_q + MS_ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign freq          = freq_q;
  assign volume        = vol_q;
  assign output_enable = oe_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign cur_idx       = idx_q[AW-1:0];

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed, table-driven and randomized checks of
// tone_sequencer at 10 kHz clock (10 cycles per ms), DEPTH=4.
module tb_tone_sequencer;

`ifdef TONE_SEQ_GAP_EN
  localparam int GAPC = 10;
`else
  localparam int GAPC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [23:0] wr_freq = '0;
  logic        wr_vol = 1'b0;
  logic [15:0] wr_dur = '0;
  logic [2:0]  seq_len = '0;
  logic        loop_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [23:0] freq;
  logic        volume, output_enable, busy, done;
  logic [1:0]  cur_idx;

  int checks = 0;
  int errors = 0;

  logic [23:0] tf [4];
  logic        tv [4];
  logic [15:0] td [4];

  typedef struct packed {
    logic        busy;
    logic [23:0] f;
    logic        v;
    logic        oe;
    logic        done;
    logic [1:0]  idx;
    logic        ci;
  } exp_t;

  typedef struct {
    int len;
    int dur [4];
    int exp_busy;
  } vec_t;

  exp_t q [$];
  vec_t vt [5];

  tone_sequencer #(
    .CLK_HZ(10_000), .DEPTH(4), .FREQ_W(24),
    .DUR_W(16), .GAP_MS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_freq(wr_freq), .wr_vol(wr_vol),
    .wr_dur(wr_dur), .seq_len(seq_len),
    .loop_en(loop_en), .start(start),
    .stop(stop), .freq(freq),
    .volume(volume),
    .output_enable(output_enable),
    .busy(busy), .done(done),
    .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(int a, int f, bit v, int d);
    wr_en   = 1'b1;
    wr_addr = a[1:0];
    wr_freq = f[23:0];
    wr_vol  = v;
    wr_dur  = d[15:0];
    tf[a]   = f[23:0];
    tv[a]   = v;
    td[a]   = d[15:0];
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (busy && n < 400) begin
      n++;
      tick(1);
    end
    if (busy) chk(nm, 32'(busy), 32'd0);
    tick(2);
  endtask

  function automatic exp_t mk(bit b, logic [23:0] f,
      bit v, bit o, bit d, int idx, bit ci);
    exp_t e;
    e.busy = b; e.f = f; e.v = v; e.oe = o;
    e.done = d; e.idx = idx[1:0]; e.ci = ci;
    return e;
  endfunction

  // Expected per-cycle trace of one non-looping run,
  // starting with the cycle after the start edge.
  task automatic model(int len);
    logic [23:0] f = '0;
    bit v = 0;
    bit o = 0;
    q.delete();
    for (int k = 0; k < len; k++) begin
      q.push_back(mk(1, f, v, o, 0, k, 1));
      if (td[k] != 0) begin
        f = tf[k]; v = tv[k]; o = 1;
        repeat (int'(td[k]) * 10)
          q.push_back(mk(1, f, v, 1, 0, k, 1));
        if (GAPC > 0) begin
          f = '0; v = 0;
          repeat (GAPC)
            q.push_back(mk(1, '0, 0, 1, 0, k, 1));
        end
      end
    end
    q.push_back(mk(0, '0, 0, 0, 1, 0, 0));
    q.push_back(mk(0, '0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    int dn;
    int cnt;
    int ln;
    exp_t e;

    vt[0] = '{2, '{3, 2, 0, 0}, 52 + 2*GAPC};
    vt[1] = '{3, '{3, 0, 2, 0}, 53 + 2*GAPC};
    vt[2] = '{1, '{1, 0, 0, 0}, 11 + GAPC};
    vt[3] = '{4, '{0, 0, 0, 0}, 4};
    vt[4] = '{3, '{2, 1, 1, 3}, 43 + 3*GAPC};

    tick(2);
    chk("rst_state",
        {busy, done, output_enable, volume, freq},
        32'd0);
    rst = 1'b0;
    tick(1);

    // basic two-note play
    wr(0, 500, 0, 3);
    wr(1, 220, 1, 2);
    seq_len = 3'd2;
    go();
    chk("t2_load0", {busy, cur_idx}, {1'b1, 2'd0});
    tick(1);
    for (int i = 0; i < 30; i++) begin
      chk("t2_note0", {busy, output_enable, volume, freq},
          {1'b1, 1'b1, 1'b0, 24'd500});
      tick(1);
    end
    for (int i = 0; i < GAPC; i++) begin
      chk("t2_gap0", {output_enable, volume, freq},
          {1'b1, 1'b0, 24'd0});
      tick(1);
    end
    chk("t2_load1", {busy, cur_idx}, {1'b1, 2'd1});
    tick(1);
    for (int i = 0; i < 20; i++) begin
      chk("t2_note1", {busy, output_enable, volume, freq},
          {1'b1, 1'b1, 1'b1, 24'd220});
      tick(1);
    end
    for (int i = 0; i < GAPC; i++) begin
      chk("t2_gap1", {output_enable, volume, freq},
          {1'b1, 1'b0, 24'd0});
      tick(1);
    end
    chk("t2_end",
        {done, busy, output_enable, volume, freq},
        {1'b1, 1'b0, 1'b0, 1'b0, 24'd0});
    tick(1);
    chk("t2_done_pulse", 32'(done), 32'd0);

    // looping, then loop_en cleared
    loop_en = 1'b1;
    go();
    tick(52 + 2*GAPC);
    chk("t3_wrap_load", {busy, cur_idx}, {1'b1, 2'd0});
    tick(1);
    chk("t3_wrap_freq", {output_enable, freq},
        {1'b1, 24'd500});
    loop_en = 1'b0;
    dn = 0;
    repeat (200) begin
      if (done) dn++;
      tick(1);
    end
    chk("t3_done_once", dn, 1);
    chk("t3_idle", 32'(busy), 32'd0);

    // zero-duration entry is skipped
    wr(1, 300, 1, 0);
    wr(2, 220, 1, 2);
    seq_len = 3'd3;
    go();
    tick(31 + GAPC);
    chk("t4_skip_load", {busy, cur_idx}, {1'b1, 2'd1});
    tick(1);
    chk("t4_load2", {busy, cur_idx}, {1'b1, 2'd2});
    tick(1);
    chk("t4_note2", {output_enable, volume, freq},
        {1'b1, 1'b1, 24'd220});
    wait_idle("t4_timeout");

    // stop mid-note
    wr(1, 220, 1, 2);
    seq_len = 3'd2;
    go();
    tick(10);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("t5_stop",
        {busy, done, output_enable, volume, freq, cur_idx},
        32'd0);
    dn = 0;
    repeat (40) begin
      if (done || busy) dn++;
      tick(1);
    end
    chk("t5_no_done", dn, 0);

    // start and stop together
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    dn = 0;
    repeat (5) begin
      if (done || busy) dn++;
      tick(1);
    end
    chk("t5_start_stop", dn, 0);

    // empty sequence
    seq_len = 3'd0;
    go();
    chk("t5_len0", {done, busy}, {1'b1, 1'b0});
    tick(1);
    chk("t5_len0_after", {done, busy}, {1'b0, 1'b0});

    // async reset mid-note
    seq_len = 3'd2;
    go();
    tick(15);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_rst",
        {busy, done, output_enable, volume, freq, cur_idx},
        32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    chk("t1_after_rst", 32'(busy), 32'd0);

    // table-driven runs
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 4; k++)
        wr(k, 100 * (k + 1), k[0], vt[v].dur[k]);
      seq_len = vt[v].len[2:0];
      go();
      cnt = 0;
      while (busy && cnt < 500) begin
        cnt++;
        tick(1);
      end
      chk("vec_busy_cycles", cnt, vt[v].exp_busy);
      chk("vec_done", 32'(done), 32'd1);
      tick(2);
    end

    // randomized runs against the trace model
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 4; k++)
        wr(k,
           ($urandom_range(0, 3) == 0) ? 0
             : int'($urandom_range(1, 5000)),
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)));
      ln = int'($urandom_range(0, 4));
      seq_len = ln[2:0];
      model(ln);
      go();
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("rnd_out",
            {busy, freq, volume, output_enable, done},
            {e.busy, e.f, e.v, e.oe, e.done});
        if (e.ci) chk("rnd_idx", cur_idx, e.idx);
        tick(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
